// File: rtl/hidden_cpu_driver.sv
// hidden_cpu_driver: loads a small program, resets the HiddenCPU, streams the words and captures its output bus.
// Optional build macro DRIVER_LOOP_EN adds a stop input and continuous looped streaming.
module hidden_cpu_driver #(
  parameter int PROG_DEPTH = 16,
  parameter int CAP_DEPTH  = 8,
  parameter int RST_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load_valid,
  input  logic [5:0]                  load_data,
  output logic                        load_ready,
  input  logic [$clog2(PROG_DEPTH):0] prog_len,
  input  logic                        start,
`ifdef DRIVER_LOOP_EN
  input  logic                        stop,
`endif
  output logic                        busy,
  output logic                        done,
  output logic                        overflow,
  output logic [5:0]                  instr_out,
  output logic                        cpu_rst,
  input  logic [7:0]                  cpu_out,
  output logic                        cap_valid,
  output logic [7:0]                  cap_data,
  input  logic                        cap_ready
);

  localparam int AW = $clog2(PROG_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(CAP_DEPTH);
  localparam int FW = CW + 1;
  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CPURST = 2'd1,
    RUN    = 2'd2
  } state_t;

  state_t        state;
  logic [5:0]    mem [PROG_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] pc;
  logic [AW:0]   len;
  logic [RW-1:0] rcnt;
  logic          cap_en;
  logic [7:0]    fifo [CAP_DEPTH];
  logic [CW-1:0] frd;
  logic [CW-1:0] fwr;
  logic [FW-1:0] fcnt;

  logic          wr_en;
  logic          last_word;
  logic          last;
  logic [AW-1:0] pc_nxt;
  logic [AW:0]   len_clamped;
  logic          pop;
  logic          full;
  logic          push;
  logic [FW-1:0] fcnt_nxt;
  logic [CW-1:0] frd_inc;

  // Next-state helpers for the sequencer and the capture FIFO.
  always_comb begin
    len_clamped = (prog_len > LW'(PROG_DEPTH)) ? LW'(PROG_DEPTH) : prog_len;
    last_word   = ({1'b0, pc} == (len - LW'(1)));
`ifdef DRIVER_LOOP_EN
    last        = stop;
    pc_nxt      = last_word ? '0 : pc + AW'(1);
`else
    last        = last_word;
    pc_nxt      = pc + AW'(1);
`endif
    wr_en       = (state == IDLE) && load_valid && !start && !rst;
    pop         = cap_valid && cap_ready;
    full        = (fcnt == FW'(CAP_DEPTH));
    // A full FIFO still accepts a sample when the head leaves on the same edge.
    push        = cap_en && (!full || pop);
    fcnt_nxt    = fcnt + FW'(push) - FW'(pop);
    frd_inc     = frd + CW'(1);
  end

  // Storage arrays; program memory deliberately survives reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= load_data;
    if (push && !rst) fifo[fwr] <= cpu_out;
  end

  // Sequencer: IDLE -> CPURST -> RUN -> IDLE with registered pin outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wptr       <= '0;
      pc         <= '0;
      len        <= '0;
      rcnt       <= '0;
      instr_out  <= 6'd0;
      cpu_rst    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          cpu_rst    <= 1'b1;
          instr_out  <= 6'd0;
          busy       <= 1'b0;
          load_ready <= 1'b1;
          if (start) begin
            wptr <= '0;
            if (prog_len == '0) begin
              done <= 1'b1;
            end else begin
              len        <= len_clamped;
              pc         <= '0;
              rcnt       <= '0;
              instr_out  <= mem[0];
              busy       <= 1'b1;
              load_ready <= 1'b0;
              state      <= CPURST;
            end
          end else if (load_valid) begin
            wptr <= wptr + AW'(1);
          end
        end
        CPURST: begin
          if (rcnt == RW'(RST_CYCLES - 1)) begin
            cpu_rst <= 1'b0;
            state   <= RUN;
          end else begin
            rcnt <= rcnt + RW'(1);
          end
        end
        RUN: begin
          if (last) begin
            instr_out  <= 6'd0;
            cpu_rst    <= 1'b1;
            busy       <= 1'b0;
            load_ready <= 1'b1;
            done       <= 1'b1;
            state      <= IDLE;
          end else begin
            pc        <= pc_nxt;
            instr_out <= mem[pc_nxt];
          end
        end
        default: begin
          state      <= IDLE;
          cpu_rst    <= 1'b1;
          instr_out  <= 6'd0;
          busy       <= 1'b0;
          load_ready <= 1'b1;
        end
      endcase
    end
  end

  // Capture FIFO control; the head is kept in a register so cap_data is glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_en    <= 1'b0;
      frd       <= '0;
      fwr       <= '0;
      fcnt      <= '0;
      cap_valid <= 1'b0;
      cap_data  <= 8'h00;
      overflow  <= 1'b0;
    end else begin
      cap_en    <= (state == RUN);
      if (push) fwr <= fwr + CW'(1);
      if (pop) frd <= frd_inc;
      fcnt      <= fcnt_nxt;
      cap_valid <= (fcnt_nxt != '0);
      if (fcnt_nxt == '0) cap_data <= 8'h00;
      else if (pop) cap_data <= (fcnt == FW'(1)) ? cpu_out : fifo[frd_inc];
      else if (fcnt == '0) cap_data <= cpu_out;
      if (cap_en && full && !pop) overflow <= 1'b1;
      else if ((state == IDLE) && start) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hidden_cpu_driver.sv
// Self-checking bench for hidden_cpu_driver: table of runs plus hand-written corner sequences,
// checked against a timeline/queue model of the driver.
module tb_hidden_cpu_driver;

  localparam int PD = 16;
  localparam int CD = 8;
  localparam int RC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_valid = 1'b0;
  logic [5:0] load_data = 6'd0;
  logic       load_ready;
  logic [4:0] prog_len = 5'd0;
  logic       start = 1'b0;
  logic       busy;
  logic       done;
  logic       overflow;
  logic [5:0] instr_out;
  logic       cpu_rst;
  logic [7:0] cpu_out = 8'd0;
  logic       cap_valid;
  logic [7:0] cap_data;
  logic       cap_ready = 1'b0;

  always #5 clk = ~clk;

  hidden_cpu_driver #(.PROG_DEPTH(PD), .CAP_DEPTH(CD), .RST_CYCLES(RC)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .prog_len(prog_len), .start(start), .busy(busy),
    .done(done), .overflow(overflow), .instr_out(instr_out), .cpu_rst(cpu_rst),
    .cpu_out(cpu_out), .cap_valid(cap_valid), .cap_data(cap_data), .cap_ready(cap_ready)
  );

  int         ntests = 0;
  int         nfail  = 0;
  logic [5:0] pmem [PD];
  int         wp = 0;
  logic [7:0] mq [$];
  bit         movf = 1'b0;
  int         rmode = 0;

  typedef struct {
    logic [4:0] plen;
    int         nload;
    int         rmode;
    int         exp_n;
    int         exp_ovf;
    int         exp_cnt;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // One clock: drive cpu_out/cap_ready, advance the FIFO model, then compare FIFO outputs.
  task automatic step(input bit cap_now);
    bit pop;
    cpu_out = 8'($urandom);
    case (rmode)
      0: cap_ready = 1'b0;
      1: cap_ready = 1'b1;
      2: cap_ready = 1'($urandom);
      3: cap_ready = cap_now;
      default: cap_ready = 1'b0;
    endcase
    if (rst) begin
      mq.delete();
      movf = 1'b0;
      wp   = 0;
    end else begin
      pop = (mq.size() > 0) && cap_ready;
      if (pop) void'(mq.pop_front());
      if (cap_now) begin
        if (mq.size() < CD) mq.push_back(cpu_out);
        else movf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("cap_valid", cap_valid, mq.size() > 0);
    if (mq.size() > 0) chk("cap_data", cap_data, mq[0]);
    chk("overflow", overflow, movf);
  endtask

  task automatic load_word(input logic [5:0] d);
    chk("load_ready", load_ready, 1);
    load_valid = 1'b1;
    load_data  = d;
    pmem[wp]   = d;
    wp         = (wp + 1) % PD;
    step(1'b0);
    load_valid = 1'b0;
  endtask

  task automatic drain(input int exp_cnt);
    int cnt = 0;
    rmode = 1;
    for (int i = 0; i < 40 && cap_valid; i++) begin
      cnt++;
      step(1'b0);
    end
    chk("drain_bound", cap_valid, 0);
    if (exp_cnt >= 0) chk("drain_cnt", cnt, exp_cnt);
  endtask

  // Start a run and follow the expected pin timeline: RC reset cycles, n words, done cycle.
  task automatic run(input logic [4:0] plen, input int exp_n, input int mode);
    rmode      = mode;
    start      = 1'b1;
    prog_len   = plen;
    load_valid = 1'b1;
    load_data  = 6'($urandom);
    movf       = 1'b0;
    wp         = 0;
    step(1'b0);
    start      = 1'b0;
    load_valid = 1'b0;
    if (exp_n == 0) begin
      chk("zero_done", done, 1);
      chk("zero_busy", busy, 0);
      chk("zero_cpu_rst", cpu_rst, 1);
      chk("zero_load_ready", load_ready, 1);
      step(1'b0);
      chk("zero_done_end", done, 0);
    end else begin
      for (int i = 0; i < RC; i++) begin
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_busy", busy, 1);
        chk("rst_load_ready", load_ready, 0);
        chk("rst_instr", instr_out, pmem[0]);
        chk("rst_done", done, 0);
        start    = 1'($urandom);
        prog_len = 5'($urandom);
        step(1'b0);
      end
      for (int k = 0; k < exp_n; k++) begin
        chk("run_cpu_rst", cpu_rst, 0);
        chk("run_instr", instr_out, pmem[k]);
        chk("run_busy", busy, 1);
        chk("run_done", done, 0);
        start    = 1'($urandom);
        prog_len = 5'($urandom);
        step(k > 0);
      end
      start = 1'b0;
      chk("fin_done", done, 1);
      chk("fin_busy", busy, 0);
      chk("fin_cpu_rst", cpu_rst, 1);
      chk("fin_instr", instr_out, 0);
      step(1'b1);
      chk("fin_done_end", done, 0);
    end
  endtask

  initial begin
    vecs[0] = '{5'd4,  -1, 0, 4,  0,  4};
    vecs[1] = '{5'd12,  5, 0, 12, 1,  8};
    vecs[2] = '{5'd3,   3, 1, 3,  0, -1};
    vecs[3] = '{5'd0,   2, 0, 0,  0,  0};
    vecs[4] = '{5'd31,  4, 0, 16, 1,  8};
    vecs[5] = '{5'd16,  6, 2, 16, -1, -1};
    vecs[6] = '{5'd7,   1, 2, 7,  -1, -1};
    vecs[7] = '{5'd1,   1, 0, 1,  0,  1};
    vecs[8] = '{5'd17,  0, 1, 16, 0, -1};
    vecs[9] = '{5'd2,   0, 3, 2,  0, -1};

    rst = 1'b1;
    step(1'b0);
    step(1'b0);
    chk("reset_cpu_rst", cpu_rst, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_instr", instr_out, 0);
    chk("reset_load_ready", load_ready, 1);
    chk("reset_cap_data", cap_data, 0);
    rst = 1'b0;

    for (int i = 0; i < PD; i++) load_word(6'($urandom));

    for (int v = 0; v < 10; v++) begin
      drain(-1);
      if (vecs[v].nload < 0) begin
        load_word(6'h01);
        load_word(6'h02);
        load_word(6'h03);
        load_word(6'h3F);
      end else begin
        for (int j = 0; j < vecs[v].nload; j++) load_word(6'($urandom));
      end
      run(vecs[v].plen, vecs[v].exp_n, vecs[v].rmode);
      if (vecs[v].exp_ovf >= 0) chk("vec_ovf", overflow, vecs[v].exp_ovf);
      if (vecs[v].exp_cnt >= 0) drain(vecs[v].exp_cnt);
    end

    // Full FIFO with a simultaneous pop on every capture cycle.
    drain(-1);
    run(5'd8, 8, 0);
    chk("fpp_pre_ovf", overflow, 0);
    run(5'd3, 3, 3);
    chk("fpp_ovf", overflow, 0);
    drain(8);

    // Reset on the third RUN cycle aborts without a done pulse.
    drain(-1);
    rmode    = 1;
    start    = 1'b1;
    prog_len = 5'd4;
    movf     = 1'b0;
    wp       = 0;
    step(1'b0);
    start = 1'b0;
    step(1'b0);
    step(1'b0);
    step(1'b0);
    step(1'b1);
    chk("mr_instr", instr_out, pmem[2]);
    chk("mr_cpu_rst_run", cpu_rst, 0);
    rst = 1'b1;
    step(1'b1);
    rst = 1'b0;
    chk("mr_cpu_rst", cpu_rst, 1);
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_instr_zero", instr_out, 0);
    chk("mr_load_ready", load_ready, 1);
    step(1'b0);
    chk("mr_done_after", done, 0);
    chk("mr_busy_after", busy, 0);

    load_word(6'($urandom));
    run(5'd5, 5, 2);
    drain(-1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/hidden_cpu_driver.md
Name: hidden_cpu_driver

Overview:
- Host-side counterpart to the HiddenCPU pin interface: the block that sources the CPU's `{instruction[5:0], rst}` inputs and sinks its 8-bit output bus.
- Holds a small program memory loaded over a valid/ready port.
- On start, resets the CPU, streams the program one instruction per clock, and captures the CPU output bus into a capture FIFO that the host drains via valid/ready.
- Sits between the test/host logic and the CPU core instance.

Parameters:
- PROG_DEPTH, 16, number of 6-bit program words (power of 2, ≥2)
- CAP_DEPTH, 8, capture FIFO entries (power of 2, ≥2)
- RST_CYCLES, 2, cycles `cpu_rst` is held high before streaming (≥1)

Ports:
- clk  in  1  system clock, shared with the CPU
- rst  in  1  synchronous active-high reset
- load_valid  in  1  program word write strobe
- load_data  in  6  program word
- load_ready  out  1  high only in IDLE
- prog_len  in  log2(PROG_DEPTH)+1  number of words to run, sampled on start
- start  in  1  begin run; honoured only in IDLE
- busy  out  1  high in CPURST or RUN
- done  out  1  one-cycle pulse when a run finishes
- overflow  out  1  sticky: a capture sample was dropped
- instr_out  out  6  drives CPU `instruction[5:0]`
- cpu_rst  out  1  drives CPU `rst`
- cpu_out  in  8  CPU output bus
- cap_valid  out  1  capture FIFO non-empty
- cap_data  out  8  FIFO head
- cap_ready  in  1  host pops when `cap_valid && cap_ready`

Behaviour:
- Reset (rst=1 on a clk edge):
  - state=IDLE; write pointer, program counter and FIFO pointers cleared; FIFO emptied.
  - Output values: `instr_out`=0, `cpu_rst`=1, `busy`=0, `done`=0, `overflow`=0, `cap_valid`=0, `cap_data`=0, `load_ready`=1.
  - Program memory contents are not cleared.
- IDLE:
  - `cpu_rst`=1, `instr_out`=0.
  - `load_valid` writes `load_data` to `mem[wptr]`, then wptr++. wptr wraps modulo PROG_DEPTH.
  - `start` with `prog_len`==0 → single-cycle `done` pulse, stay IDLE.
  - `start` with `prog_len`>PROG_DEPTH → clamp to PROG_DEPTH.
  - Otherwise latch len; pc=0; cnt=0; go to CPURST. wptr resets to 0 on start.
  - If `start` and `load_valid` arrive together, start wins and the write is ignored.
- CPURST:
  - `cpu_rst`=1 for exactly RST_CYCLES cycles, `instr_out`=`mem[0]`; then go to RUN.
- RUN:
  - `cpu_rst`=0, `instr_out`=`mem[pc]`, registered.
  - Each cycle pc++ until pc==len-1. The cycle after the last word is issued: `instr_out`=0, state → IDLE, `done`=1 for one cycle.
  - Capture: a 1-cycle delayed enable pushes `cpu_out` into the FIFO once per issued instruction. The sample is taken the cycle after each word is presented, so exactly len samples are captured per run, the last in the `done` cycle.
- FIFO:
  - Push when enabled and not full.
  - Push when full → sample dropped, `overflow` set (cleared only by rst or by start).
  - Pop on `cap_valid && cap_ready`. Simultaneous push and pop when full is allowed, no overflow.
  - `cap_data` is the registered head, valid whenever `cap_valid`. The FIFO persists across IDLE until drained.
- `start` during CPURST or RUN is ignored.
- `rst` mid-run aborts immediately to the reset values; no `done` pulse.

Optional Feature:
- DRIVER_LOOP_EN:
  - When defined: adds input `stop` (1 bit). In RUN, after issuing `mem[len-1]` the pc wraps to 0 and streaming continues indefinitely without reasserting `cpu_rst`. `stop` makes the current word the last issued, then the normal done sequence runs. Captures continue every cycle, so overflow is expected if the host does not drain.
  - When undefined: no `stop` port; single pass as above.

Test Plan:
- Reset values: assert rst 2 cycles → `cpu_rst`=1, `busy`=0, `cap_valid`=0, `overflow`=0, `instr_out`=0.
- Load and run: load 0x01,0x02,0x03,0x3F; start with `prog_len`=4 → `cpu_rst` high for 2 cycles, then `instr_out` = 0x01,0x02,0x03,0x3F on consecutive cycles, `done` pulse 1 cycle after 0x3F, 4 FIFO entries equal to the `cpu_out` values sampled.
- Overflow: CAP_DEPTH=8, prog_len=12, `cap_ready`=0 → 8 entries held, `overflow`=1; next start clears `overflow`.
- Zero and clamp: `prog_len`=0 → immediate `done`, no `cpu_rst` drop. `prog_len`=31 with PROG_DEPTH=16 → exactly 16 words issued.
- Mid-run reset: assert rst on the 3rd RUN cycle → next cycle IDLE, `cpu_rst`=1, FIFO empty, no `done`.
- Full push+pop: FIFO full, `cap_ready`=1 during a capture cycle → count stays 8, `overflow` stays 0, head advances.
